// File: rtl/dfp_pack96_pkg.sv
// Shared definitions for the DFP96 packer: field positions, special combination
// codes, FSM states and a BCD digit clamp.
package dfp_pack96_pkg;

   localparam int SIGN_BIT  = 95;
   localparam int COMBO_LSB = 90;
   localparam int EXPC_LSB  = 80;

   localparam logic [4:0] COMBO_INF = 5'b11110;
   localparam logic [4:0] COMBO_NAN = 5'b11111;

   typedef enum logic [1:0] {
      IDLE,
      ENC,
      DONE
   } state_t;

   // Non-canonical nibbles (>9) saturate to 9.
   function automatic logic [3:0] clamp_digit(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

endpackage

// File: rtl/dfp_bcd2dpd.sv
// Combinational IEEE 754-2008 densely-packed-decimal encoder: three BCD digits
// (hundreds in [11:8]) to one 10-bit declet. Inputs are assumed canonical.
module dfp_bcd2dpd (
   input  logic [11:0] bcd,
   output logic [9:0]  dpd
);

   logic a, b, c, d, e, f, g, h, i, j, k, m;

   assign {a, b, c, d} = bcd[11:8];
   assign {e, f, g, h} = bcd[7:4];
   assign {i, j, k, m} = bcd[3:0];

   // The large-digit indicators a/e/i select which bits get compressed.
   always_comb begin
      dpd = '0;
      unique case ({a, e, i})
         3'b000: dpd = {b, c, d, f, g, h, 1'b0, j, k, m};
         3'b001: dpd = {b, c, d, f, g, h, 1'b1, 1'b0, 1'b0, m};
         3'b010: dpd = {b, c, d, j, k, h, 1'b1, 1'b0, 1'b1, m};
         3'b011: dpd = {b, c, d, 1'b1, 1'b0, h, 1'b1, 1'b1, 1'b1, m};
         3'b100: dpd = {j, k, d, f, g, h, 1'b1, 1'b1, 1'b0, m};
         3'b101: dpd = {f, g, d, 1'b0, 1'b1, h, 1'b1, 1'b1, 1'b1, m};
         3'b110: dpd = {j, k, d, 1'b0, 1'b0, h, 1'b1, 1'b1, 1'b1, m};
         3'b111: dpd = {1'b0, 1'b0, d, 1'b1, 1'b1, h, 1'b1, 1'b1, 1'b1, m};
         default: dpd = '0;
      endcase
   end

endmodule

// File: rtl/dfp_pack96.sv
// Multi-cycle DFP96 packer: encodes one declet per enabled clock, then assembles
// sign, combination field and exponent continuation into the interchange word.
module dfp_pack96
   import dfp_pack96_pkg::*;
#(
   parameter int NDECL = 8,
   parameter int N     = 25
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ce,
   input  logic           i_valid,
   output logic           i_ready,
   input  logic           sign,
   input  logic [11:0]    exp,
   input  logic [4*N-1:0] sig,
   input  logic           nan,
   input  logic           snan,
   input  logic           infinity,
   output logic           o_valid,
   input  logic           o_ready,
   output logic [95:0]    o,
   output logic           o_inv,
   output logic           o_ovf
);

   localparam int CW = $clog2(NDECL);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             sign_r;
   logic [11:0]      exp_r;
   logic [4*N-1:0]   sig_r;

   logic [11:0]      cur_raw;
   logic [11:0]      cur_bcd;
   logic             cur_inv;
   logic [9:0]       cur_dpd;
   logic [3:0]       lead_raw;
   logic [3:0]       lead;
   logic [4:0]       combo;

   assign i_ready = (state == IDLE);

   // Select and sanitise the declet addressed by the counter.
   always_comb begin
      cur_raw = sig_r[12*cnt +: 12];
      cur_bcd = {clamp_digit(cur_raw[11:8]), clamp_digit(cur_raw[7:4]),
                 clamp_digit(cur_raw[3:0])};
      cur_inv = (cur_raw[11:8] > 4'd9) | (cur_raw[7:4] > 4'd9) |
                (cur_raw[3:0] > 4'd9);
   end

   // Lead digit folds into the combination field rather than a declet.
   always_comb begin
      lead_raw = sig_r[4*N-1 -: 4];
      lead     = clamp_digit(lead_raw);
      if (lead < 4'd8)
         combo = {exp_r[11:10], lead[2:0]};
      else
         combo = {2'b11, exp_r[11:10], lead[0]};
   end

   dfp_bcd2dpd u_bcd2dpd (
      .bcd (cur_bcd),
      .dpd (cur_dpd)
   );

   // Main FSM: capture in IDLE, one declet per ENC edge, hold result in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         sign_r  <= 1'b0;
         exp_r   <= '0;
         sig_r   <= '0;
         o       <= '0;
         o_valid <= 1'b0;
         o_inv   <= 1'b0;
         o_ovf   <= 1'b0;
      end else if (ce) begin
         unique case (state)
            IDLE: begin
               if (i_valid) begin
                  o_inv <= 1'b0;
                  o_ovf <= 1'b0;
                  cnt   <= '0;
                  if (nan) begin
                     o                           <= '0;
                     o[SIGN_BIT]                 <= sign;
                     o[COMBO_LSB +: 5]           <= COMBO_NAN;
                     o[COMBO_LSB-1]              <= snan;
                     o_valid                     <= 1'b1;
                     state                       <= DONE;
                  end else if (infinity || (exp[11:10] == 2'b11)) begin
                     o                           <= '0;
                     o[SIGN_BIT]                 <= sign;
                     o[COMBO_LSB +: 5]           <= COMBO_INF;
                     o_ovf                       <= ~infinity;
                     o_valid                     <= 1'b1;
                     state                       <= DONE;
                  end else begin
                     sign_r <= sign;
                     exp_r  <= exp;
                     sig_r  <= sig;
                     state  <= ENC;
                  end
               end
            end
            ENC: begin
               o[10*cnt +: 10] <= cur_dpd;
               cnt             <= cnt + 1'b1;
               if (cnt == CW'(NDECL-1)) begin
                  o[SIGN_BIT]         <= sign_r;
                  o[COMBO_LSB +: 5]   <= combo;
                  o[EXPC_LSB +: 10]   <= exp_r[9:0];
                  o_inv               <= o_inv | cur_inv | (lead_raw > 4'd9);
                  o_valid             <= 1'b1;
                  state               <= DONE;
               end else begin
                  o_inv <= o_inv | cur_inv;
               end
            end
            DONE: begin
               if (o_ready) begin
                  o_valid <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dfp_pack96.sv
// Directed self-checking bench for dfp_pack96 with hand-computed DPD words.
module tb_dfp_pack96;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ce = 1'b1;
   logic         i_valid = 1'b0;
   logic         i_ready;
   logic         sign = 1'b0;
   logic [11:0]  exp = '0;
   logic [99:0]  sig = '0;
   logic         nan = 1'b0;
   logic         snan = 1'b0;
   logic         infinity = 1'b0;
   logic         o_valid;
   logic         o_ready = 1'b0;
   logic [95:0]  o;
   logic         o_inv;
   logic         o_ovf;

   int n_cmp = 0;
   int n_err = 0;
   int lat;
   logic [95:0] held;

   always #5 clk = ~clk;

   dfp_pack96 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ce       (ce),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .sign     (sign),
      .exp      (exp),
      .sig      (sig),
      .nan      (nan),
      .snan     (snan),
      .infinity (infinity),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .o        (o),
      .o_inv    (o_inv),
      .o_ovf    (o_ovf)
   );

   task automatic check_output(input string tag, input logic [95:0] got,
                               input logic [95:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Present one operand, accept it, and count edges (accept edge = 1) to o_valid.
   task automatic apply_stimulus(input logic s, input logic [11:0] e,
                                 input logic [99:0] g, input logic is_nan,
                                 input logic is_snan, input logic is_inf,
                                 output int latency);
      sign = s; exp = e; sig = g; nan = is_nan; snan = is_snan; infinity = is_inf;
      i_valid = 1'b1;
      check_output("i_ready_idle", 96'(i_ready), 96'd1);
      @(posedge clk); #1;
      i_valid = 1'b0;
      latency = 1;
      while (!o_valid && latency < 40) begin
         @(posedge clk); #1;
         latency++;
      end
      check_output("o_valid_seen", 96'(o_valid), 96'd1);
   endtask

   task automatic consume();
      o_ready = 1'b1;
      @(posedge clk); #1;
      o_ready = 1'b0;
      check_output("o_valid_drop", 96'(o_valid), 96'd0);
      check_output("i_ready_back", 96'(i_ready), 96'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_o", o, 96'h0);
      check_output("rst_o_valid", 96'(o_valid), 96'd0);
      check_output("rst_i_ready", 96'(i_ready), 96'd1);
      check_output("rst_flags", 96'({o_inv, o_ovf}), 96'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Smallest finite value
      apply_stimulus(1'b0, 12'h000, 100'h1, 1'b0, 1'b0, 1'b0, lat);
      check_output("t1_o", o, 96'h000000000000000000000001);
      check_output("t1_lat", 96'(lat), 96'd9);
      check_output("t1_flags", 96'({o_inv, o_ovf}), 96'd0);
      consume();

      // All nines: lead 9 uses the 11xx combination form
      apply_stimulus(1'b0, 12'h000, {25{4'h9}}, 1'b0, 1'b0, 1'b0, lat);
      check_output("t2_o", o, {16'h6400, {8{10'h0FF}}});
      check_output("t2_inv", 96'(o_inv), 96'd0);
      consume();

      // Infinity with overflowing exponent: infinity wins, no o_ovf
      apply_stimulus(1'b1, 12'hC00, 100'h5, 1'b0, 1'b0, 1'b1, lat);
      check_output("t3_inf_o", o, 96'hF80000000000000000000000);
      check_output("t3_inf_lat", 96'(lat), 96'd1);
      check_output("t3_inf_ovf", 96'(o_ovf), 96'd0);
      consume();

      apply_stimulus(1'b0, 12'h123, 100'h7, 1'b1, 1'b1, 1'b1, lat);
      check_output("t3_nan_o", o, 96'h7E0000000000000000000000);
      check_output("t3_nan_lat", 96'(lat), 96'd1);
      consume();

      // Finite overflow
      apply_stimulus(1'b0, 12'hC00, 100'h1, 1'b0, 1'b0, 1'b0, lat);
      check_output("t4_o", o, 96'h780000000000000000000000);
      check_output("t4_ovf", 96'(o_ovf), 96'd1);
      check_output("t4_lat", 96'(lat), 96'd1);
      consume();

      // Lead 5, exponent 0x5A5, negative, low declet 123 -> 0A3
      apply_stimulus(1'b1, 12'h5A5, {4'h5, 96'h123}, 1'b0, 1'b0, 1'b0, lat);
      check_output("t5_o", o, 96'hB5A5_0000_0000_0000_0000_00A3);
      held = o;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check_output("bp_o", o, held);
         check_output("bp_valid_ready", 96'({o_valid, i_ready}), 96'b10);
      end
      consume();

      // Declets 089 -> 04F and 980 -> 08E, with ce low for three edges
      fork
         apply_stimulus(1'b0, 12'h000, 100'h980089, 1'b0, 1'b0, 1'b0, lat);
         begin
            repeat (2) @(posedge clk);
            #1 ce = 1'b0;
            repeat (3) @(posedge clk);
            #1 ce = 1'b1;
         end
      join
      check_output("ce_o", o, 96'h00000000000000000002384F);
      check_output("ce_lat", 96'(lat), 96'd12);
      consume();

      // Non-canonical lead digit F is treated as 9
      apply_stimulus(1'b0, 12'h000, {4'hF, 96'h0}, 1'b0, 1'b0, 1'b0, lat);
      check_output("lead_o", o, {16'h6400, 80'h0});
      check_output("lead_inv", 96'(o_inv), 96'd1);
      consume();

      // Reset in the middle of encoding drops the operand
      sign = 1'b1; exp = 12'h001; sig = {25{4'h9}};
      i_valid = 1'b1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check_output("mid_rst_o", o, 96'h0);
      check_output("mid_rst_state", 96'({o_valid, i_ready, o_inv, o_ovf}), 96'b0100);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      apply_stimulus(1'b0, 12'h000, 100'hA, 1'b0, 1'b0, 1'b0, lat);
      check_output("t6_o", o, 96'h000000000000000000000009);
      check_output("t6_inv", 96'(o_inv), 96'd1);
      check_output("t6_lat", 96'(lat), 96'd9);
      consume();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
